uart_rx_fifo_fsm: RTL and testbench

UART_RX_FIFO_FSM -- requirements
Module: uart_rx_fifo_fsm

---
 rtl/uart_rx_fifo_fsm_pkg.sv | 16 +
 rtl/uart_rx_fifo_fsm.sv | 119 +++++++++++
 tb/tb_uart_rx_fifo_fsm.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_fsm_pkg.sv
// Shared UART receive definitions: FSM state encoding and line-framing defaults.
package uart_rx_fifo_fsm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } rx_state_e;

    localparam logic [7:0] DEFAULT_TERM_CHAR = 8'h0D;
    localparam int         DEFAULT_MAX_LINE  = 32;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_fsm.sv
// UART receive byte buffer: one-deep holding register feeding an RX FIFO,
// with line framing (terminator / length limit) and overflow accounting.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | holding register empty, waiting for a byte
// ST_PUSH | holding register full, offering it to FIFO
module uart_rx_fifo_fsm
    import uart_rx_fifo_fsm_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = DEFAULT_TERM_CHAR,
    parameter int         MAX_LINE  = DEFAULT_MAX_LINE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic       i_fifo_full,
    output logic       o_fifo_push,
    output logic [7:0] o_fifo_push_data,
    input  logic       i_clr_err,
    output logic       o_line_done,
    output logic [5:0] o_line_len,
    output logic       o_line_trunc,
    output logic       o_overflow,
    output logic [7:0] o_drop_cnt
);

    localparam logic [5:0] MAX_LEN = 6'(MAX_LINE);

    rx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [5:0] line_cnt_q;
    logic [5:0] line_cnt_inc;
    logic       push_ok;
    logic       drop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        push_ok = 1'b0;
        drop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    hold_d  = i_rx_data;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (!i_fifo_full) begin
                    push_ok = 1'b1;
                    if (i_rx_done) begin
                        hold_d = i_rx_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // FIFO stalled: keep the older byte, lose the newcomer.
                    drop = i_rx_done;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Push is suppressed while reset is asserted so a held byte never escapes.
    assign o_fifo_push      = push_ok & reset_n;
    assign o_fifo_push_data = hold_q;
    assign line_cnt_inc     = line_cnt_q + 6'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_cnt_q   <= 6'd0;
            o_line_done  <= 1'b0;
            o_line_len   <= 6'd0;
            o_line_trunc <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_cnt   <= 8'd0;
        end else begin
            o_line_done <= 1'b0;
            if (push_ok) begin
                // Terminator takes precedence when it also lands on the length limit.
                if (hold_q == TERM_CHAR) begin
                    o_line_done  <= 1'b1;
                    o_line_len   <= line_cnt_inc;
                    o_line_trunc <= 1'b0;
                    line_cnt_q   <= 6'd0;
                end else if (line_cnt_inc == MAX_LEN) begin
                    o_line_done  <= 1'b1;
                    o_line_len   <= MAX_LEN;
                    o_line_trunc <= 1'b1;
                    line_cnt_q   <= 6'd0;
                end else begin
                    line_cnt_q <= line_cnt_inc;
                end
            end

            if (drop) begin
                o_overflow <= 1'b1;
                o_drop_cnt <= i_clr_err ? 8'd1 : sat_inc8(o_drop_cnt);
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
                o_drop_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_fsm.sv
// Directed bench for uart_rx_fifo_fsm: per-cycle vector table plus sequences
// for lines, truncation, back-to-back bytes, drop saturation and reset.
module tb_uart_rx_fifo_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_fifo_full;
    logic       o_fifo_push;
    logic [7:0] o_fifo_push_data;
    logic       i_clr_err;
    logic       o_line_done;
    logic [5:0] o_line_len;
    logic       o_line_trunc;
    logic       o_overflow;
    logic [7:0] o_drop_cnt;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo_fsm dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_rx_data        (i_rx_data),
        .i_rx_done        (i_rx_done),
        .i_fifo_full      (i_fifo_full),
        .o_fifo_push      (o_fifo_push),
        .o_fifo_push_data (o_fifo_push_data),
        .i_clr_err        (i_clr_err),
        .o_line_done      (o_line_done),
        .o_line_len       (o_line_len),
        .o_line_trunc     (o_line_trunc),
        .o_overflow       (o_overflow),
        .o_drop_cnt       (o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rx_done;
        logic [7:0] rx_data;
        logic       full;
        logic       clr;
        logic       push;
        logic [7:0] pdata;
        logic       done;
        logic [5:0] len;
        logic       trunc;
        logic       ov;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        i_rx_done   = 1'b0;
        i_rx_data   = 8'h00;
        i_fifo_full = 1'b0;
        i_clr_err   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Sends one byte with FIFO free; checks the push one cycle later and
    // returns the line outputs seen in the cycle after the push.
    task automatic send_byte(input string name, input logic [7:0] d,
                             output logic ld, output logic [5:0] len, output logic tr);
        @(negedge clk);
        i_rx_done = 1'b1;
        i_rx_data = d;
        @(negedge clk);
        i_rx_done = 1'b0;
        #2;
        check({name, " push"}, 32'(o_fifo_push), 32'd1);
        check({name, " data"}, 32'(o_fifo_push_data), 32'(d));
        @(negedge clk);
        #2;
        check({name, " no second push"}, 32'(o_fifo_push), 32'd0);
        ld  = o_line_done;
        len = o_line_len;
        tr  = o_line_trunc;
    endtask

    initial begin
        logic       ld;
        logic [5:0] len;
        logic       tr;

        //           rxd  data   full clr  push pdata  done len   tr   ov   drop
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 6'd2, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 6'd2, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 6'd2, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 6'd2, 1'b0, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 6'd2, 1'b0, 1'b1, 8'd1};
        vecs[11] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 6'd2, 1'b0, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 6'd2, 1'b0, 1'b1, 8'd1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 6'd2, 1'b0, 1'b1, 8'd1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 6'd2, 1'b0, 1'b1, 8'd1};

        reset_n     = 1'b0;
        i_rx_done   = 1'b0;
        i_rx_data   = 8'h00;
        i_fifo_full = 1'b0;
        i_clr_err   = 1'b0;

        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            i_rx_done   = vecs[i].rx_done;
            i_rx_data   = vecs[i].rx_data;
            i_fifo_full = vecs[i].full;
            i_clr_err   = vecs[i].clr;
            #2;
            check($sformatf("v%0d push", i),  32'(o_fifo_push),      32'(vecs[i].push));
            check($sformatf("v%0d pdata", i), 32'(o_fifo_push_data), 32'(vecs[i].pdata));
            check($sformatf("v%0d done", i),  32'(o_line_done),      32'(vecs[i].done));
            check($sformatf("v%0d len", i),   32'(o_line_len),       32'(vecs[i].len));
            check($sformatf("v%0d trunc", i), 32'(o_line_trunc),     32'(vecs[i].trunc));
            check($sformatf("v%0d ov", i),    32'(o_overflow),       32'(vecs[i].ov));
            check($sformatf("v%0d drop", i),  32'(o_drop_cnt),       32'(vecs[i].drop));
        end

        // 'A','B',CR spaced apart: line of 3 ended by terminator.
        do_reset();
        send_byte("lineA", 8'h41, ld, len, tr);
        check("lineA done", 32'(ld), 32'd0);
        repeat (18) @(negedge clk);
        send_byte("lineB", 8'h42, ld, len, tr);
        check("lineB done", 32'(ld), 32'd0);
        repeat (18) @(negedge clk);
        send_byte("lineCR", 8'h0D, ld, len, tr);
        check("lineCR done", 32'(ld), 32'd1);
        check("lineCR len", 32'(len), 32'd3);
        check("lineCR trunc", 32'(tr), 32'd0);

        // 32 non-terminator bytes: truncated line.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            send_byte($sformatf("trunc%0d", i), 8'h41, ld, len, tr);
            check($sformatf("trunc%0d done", i), 32'(ld), (i == 31) ? 32'd1 : 32'd0);
        end
        check("trunc len", 32'(len), 32'd32);
        check("trunc flag", 32'(tr), 32'd1);

        // Terminator arriving as byte 32 is a normal line, not a truncation.
        for (int i = 0; i < 31; i++) send_byte("fill", 8'h41, ld, len, tr);
        check("fill31 done", 32'(ld), 32'd0);
        send_byte("cr32", 8'h0D, ld, len, tr);
        check("cr32 done", 32'(ld), 32'd1);
        check("cr32 len", 32'(len), 32'd32);
        check("cr32 trunc", 32'(tr), 32'd0);

        // Back-to-back bytes on consecutive cycles.
        do_reset();
        @(negedge clk);
        i_rx_done = 1'b1;
        i_rx_data = 8'h10;
        @(negedge clk);
        i_rx_data = 8'h11;
        #2;
        check("b2b push0", 32'(o_fifo_push), 32'd1);
        check("b2b data0", 32'(o_fifo_push_data), 32'h10);
        @(negedge clk);
        i_rx_done = 1'b0;
        #2;
        check("b2b push1", 32'(o_fifo_push), 32'd1);
        check("b2b data1", 32'(o_fifo_push_data), 32'h11);
        @(negedge clk);
        #2;
        check("b2b idle", 32'(o_fifo_push), 32'd0);

        // 260 drops under full saturate the counter; clear then drain.
        do_reset();
        @(negedge clk);
        i_fifo_full = 1'b1;
        i_rx_done   = 1'b1;
        i_rx_data   = 8'h5A;
        @(negedge clk);
        i_rx_data = 8'hEE;
        for (int i = 0; i < 259; i++) begin
            @(negedge clk);
            if (i == 253) begin
                #2;
                check("sat drop254", 32'(o_drop_cnt), 32'd254);
            end
        end
        @(negedge clk);
        i_rx_done = 1'b0;
        #2;
        check("sat drop_cnt", 32'(o_drop_cnt), 32'd255);
        check("sat overflow", 32'(o_overflow), 32'd1);
        check("sat no push", 32'(o_fifo_push), 32'd0);
        check("sat held", 32'(o_fifo_push_data), 32'h5A);
        @(negedge clk);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        #2;
        check("clr drop_cnt", 32'(o_drop_cnt), 32'd0);
        check("clr overflow", 32'(o_overflow), 32'd0);
        @(negedge clk);
        i_fifo_full = 1'b0;
        #2;
        check("drain push", 32'(o_fifo_push), 32'd1);
        check("drain data", 32'(o_fifo_push_data), 32'h5A);
        @(negedge clk);
        #2;
        check("drain single", 32'(o_fifo_push), 32'd0);

        // Reset while a byte is held discards it and the partial line.
        do_reset();
        send_byte("rst pre", 8'h41, ld, len, tr);
        @(negedge clk);
        i_fifo_full = 1'b1;
        i_rx_done   = 1'b1;
        i_rx_data   = 8'h41;
        @(negedge clk);
        i_rx_data = 8'h42;
        @(negedge clk);
        i_rx_done = 1'b0;
        #2;
        check("rst held push", 32'(o_fifo_push), 32'd0);
        check("rst held ov", 32'(o_overflow), 32'd1);
        @(negedge clk);
        reset_n     = 1'b0;
        i_fifo_full = 1'b0;
        #2;
        check("rst gate push", 32'(o_fifo_push), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        check("rst after push", 32'(o_fifo_push), 32'd0);
        check("rst after data", 32'(o_fifo_push_data), 32'h00);
        check("rst after ov", 32'(o_overflow), 32'd0);
        check("rst after drop", 32'(o_drop_cnt), 32'd0);
        check("rst after done", 32'(o_line_done), 32'd0);
        send_byte("rst cr", 8'h0D, ld, len, tr);
        check("rst cr done", 32'(ld), 32'd1);
        check("rst cr len", 32'(len), 32'd1);
        check("rst cr trunc", 32'(tr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
